// File: rtl/sw_pkg.sv
// Shared types and default timing parameters for the stopwatch control block.
package sw_pkg;

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    ADJUST = 2'd2
  } state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int SYNC_STAGES_DEF     = 2;

endpackage

// File: rtl/sw_debounce.sv
// Synchronizer plus stability-counter debouncer for one raw input, with an
// optional one-cycle pulse when the debounced level rises.
module sw_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit RISE_EN         = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES-1:0] fill;
  logic [CW-1:0]          cnt;
  logic                   armed;
  logic                   sync_out;
  logic                   valid;
  logic                   accept;

  assign sync_out = sync[SYNC_STAGES-1];
  assign valid    = fill[SYNC_STAGES-1];
  assign accept   = (sync_out != level) && (cnt == LAST);

  // A button held through reset must be seen released (armed) before its
  // next debounced rise may produce an event; fill marks when the
  // synchronizer output reflects real samples rather than reset zeros.
  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      fill  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      armed <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync[0] <= raw;
      fill[0] <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync[i] <= sync[i-1];
        fill[i] <= fill[i-1];
      end

      rise <= RISE_EN && accept && sync_out && armed;

      if (sync_out != level) begin
        if (accept) begin
          level <= sync_out;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end

      if (valid && !sync_out && !level) armed <= 1'b1;
    end
  end

endmodule

// File: rtl/sw_ctrl.sv
// Stopwatch control: debounced buttons drive a PAUSED/RUN/ADJUST FSM that
// issues registered increment/clear commands and field-blanking controls.
module sw_ctrl
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic RESET_N,
  input  logic PAUSE,
  input  logic CLR,
  input  logic ADJ,
  input  logic SEL,
  input  logic tick_1hz,
  input  logic tick_2hz,
  input  logic tick_blink,
  output logic inc_sec,
  output logic inc_min,
  output logic clr,
  output logic blank_min,
  output logic blank_sec,
  output logic running
);

  logic pause_evt, clr_evt, adj_lvl, sel_lvl;
  logic pause_lvl_unused, clr_lvl_unused, adj_rise_unused, sel_rise_unused;

  sw_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RISE_EN(1'b1))
    u_pause (.clk(clk), .rst_n(RESET_N), .raw(PAUSE), .level(pause_lvl_unused), .rise(pause_evt));
  sw_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RISE_EN(1'b1))
    u_clr   (.clk(clk), .rst_n(RESET_N), .raw(CLR),   .level(clr_lvl_unused),   .rise(clr_evt));
  sw_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RISE_EN(1'b0))
    u_adj   (.clk(clk), .rst_n(RESET_N), .raw(ADJ),   .level(adj_lvl),          .rise(adj_rise_unused));
  sw_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RISE_EN(1'b0))
    u_sel   (.clk(clk), .rst_n(RESET_N), .raw(SEL),   .level(sel_lvl),          .rise(sel_rise_unused));

  state_t state, state_nxt;
  logic   resume_run, resume_nxt;
  logic   blink_phase, blink_nxt;
  logic   sec_cmd, min_cmd;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    resume_nxt = resume_run;
    sec_cmd = 1'b0;
    min_cmd = 1'b0;
    blink_nxt = blink_phase ^ tick_blink;

    case (state)
      PAUSED: begin
        if (adj_lvl) begin
          state_nxt = ADJUST;
        end else if (pause_evt) begin
          state_nxt  = RUN;
          resume_nxt = 1'b1;
        end
      end
      RUN: begin
        if (adj_lvl) begin
          state_nxt = ADJUST;
        end else begin
          sec_cmd = tick_1hz;
          if (pause_evt) begin
            state_nxt  = PAUSED;
            resume_nxt = 1'b0;
          end
        end
      end
      ADJUST: begin
        if (!adj_lvl) begin
          state_nxt = resume_run ? RUN : PAUSED;
        end else if (tick_2hz) begin
          sec_cmd = sel_lvl;
          min_cmd = !sel_lvl;
        end
      end
      default: state_nxt = PAUSED;
    endcase

    // A clear on the same cycle as a tick swallows that tick's increment.
    if (clr_evt) begin
      sec_cmd = 1'b0;
      min_cmd = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= PAUSED;
      resume_run  <= 1'b0;
      blink_phase <= 1'b0;
      inc_sec     <= 1'b0;
      inc_min     <= 1'b0;
      clr         <= 1'b0;
      blank_min   <= 1'b0;
      blank_sec   <= 1'b0;
      running     <= 1'b0;
    end else begin
      state       <= state_nxt;
      resume_run  <= resume_nxt;
      blink_phase <= blink_nxt;
      inc_sec     <= sec_cmd;
      inc_min     <= min_cmd;
      clr         <= clr_evt;
      running     <= (state_nxt == RUN);
      blank_min   <= (state_nxt == ADJUST) && blink_nxt && !sel_lvl;
      blank_sec   <= (state_nxt == ADJUST) && blink_nxt && sel_lvl;
    end
  end

endmodule

// File: tb/tb_sw_ctrl.sv
// Directed self-checking bench for sw_ctrl with default debounce/sync depths.
module tb_sw_ctrl;

  logic clk = 1'b0;
  logic RESET_N, PAUSE, CLR, ADJ, SEL, tick_1hz, tick_2hz, tick_blink;
  logic inc_sec, inc_min, clr, blank_min, blank_sec, running;

  int n_cmp = 0;
  int n_bad = 0;
  int n_sec = 0;
  int n_min = 0;
  int n_clr = 0;

  logic [5:0] outs;
  logic [2:0] cmd;
  assign outs = {running, inc_sec, inc_min, clr, blank_min, blank_sec};
  assign cmd  = {inc_sec, inc_min, clr};

  sw_ctrl dut (
    .clk(clk), .RESET_N(RESET_N), .PAUSE(PAUSE), .CLR(CLR), .ADJ(ADJ), .SEL(SEL),
    .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .tick_blink(tick_blink),
    .inc_sec(inc_sec), .inc_min(inc_min), .clr(clr),
    .blank_min(blank_min), .blank_sec(blank_sec), .running(running)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (inc_sec) n_sec++;
    if (inc_min) n_min++;
    if (clr)     n_clr++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  // One-cycle tick: 0 = tick_1hz, 1 = tick_2hz, 2 = tick_blink.
  task automatic tick(input int k);
    case (k)
      0: tick_1hz = 1'b1;
      1: tick_2hz = 1'b1;
      default: tick_blink = 1'b1;
    endcase
    step();
    tick_1hz = 1'b0;
    tick_2hz = 1'b0;
    tick_blink = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_sec = 0;
    n_min = 0;
    n_clr = 0;
  endtask

  // Long press-and-release of PAUSE: debounced rise then debounced release.
  task automatic press_pause();
    PAUSE = 1'b1;
    wait_cycles(40);
    PAUSE = 1'b0;
    wait_cycles(30);
  endtask

  initial begin
    RESET_N = 1'b0; PAUSE = 1'b0; CLR = 1'b0; ADJ = 1'b0; SEL = 1'b0;
    tick_1hz = 1'b0; tick_2hz = 1'b0; tick_blink = 1'b0;
    wait_cycles(3);
    check("reset_outputs", outs, 6'b0);
    RESET_N = 1'b1;
    wait_cycles(5);
    check("idle_after_reset", outs, 6'b0);

    // Pulse one cycle shorter than the debounce window is rejected.
    PAUSE = 1'b1;
    wait_cycles(15);
    PAUSE = 1'b0;
    wait_cycles(25);
    check("short_pause_rejected", outs, 6'b0);

    // Long press starts the watch; each 1 Hz tick yields one inc_sec a cycle later.
    press_pause();
    check("running_after_press", running, 1);
    clear_counts();
    for (int i = 0; i < 5; i++) begin
      tick(0);
      check("run_tick_inc_sec", cmd, 3'b100);
      step();
      check("run_tick_gap", cmd, 3'b000);
      wait_cycles(3);
    end
    check("run_five_inc_sec", n_sec, 5);

    // Adjust minutes: 2 Hz ticks advance minutes, 1 Hz ticks are ignored.
    ADJ = 1'b1;
    wait_cycles(25);
    check("adjust_not_running", running, 0);
    clear_counts();
    tick(1); check("adj_min_tick_a", cmd, 3'b010); step();
    tick(0); check("adj_1hz_ignored_a", cmd, 3'b000); step();
    tick(1); check("adj_min_tick_b", cmd, 3'b010); step();
    tick(0); check("adj_1hz_ignored_b", cmd, 3'b000); step();
    tick(1); check("adj_min_tick_c", cmd, 3'b010); step();
    check("adj_total_inc_min", n_min, 3);
    check("adj_total_inc_sec", n_sec, 0);
    ADJ = 1'b0;
    wait_cycles(25);
    check("adj_exit_to_run", running, 1);

    // Adjust seconds: blink toggles blank_sec only; PAUSE is discarded.
    SEL = 1'b1;
    ADJ = 1'b1;
    wait_cycles(25);
    check("sel_sec_blank_phase0", {blank_min, blank_sec}, 2'b00);
    tick(2); check("blink_on",  {blank_min, blank_sec}, 2'b01);
    tick(2); check("blink_off", {blank_min, blank_sec}, 2'b00);
    tick(2); check("blink_on2", {blank_min, blank_sec}, 2'b01);
    press_pause();
    check("pause_ignored_in_adjust", {running, blank_min, blank_sec}, 3'b001);
    tick(1); check("adj_sec_tick", cmd, 3'b100); step();
    ADJ = 1'b0;
    wait_cycles(25);
    check("resume_run_kept", outs, 6'b100000);

    // Clear coinciding with a 1 Hz tick: clear wins, state unchanged.
    clear_counts();
    CLR = 1'b1;
    wait_cycles(18);
    tick(0);
    check("clr_beats_tick", cmd, 3'b001);
    check("clr_keeps_run", running, 1);
    step();
    check("clr_one_cycle", cmd, 3'b000);
    CLR = 1'b0;
    wait_cycles(25);
    check("clr_count", n_clr, 1);
    check("clr_no_inc_sec", n_sec, 0);

    // Pause coinciding with a 1 Hz tick: increment still issues, then paused.
    PAUSE = 1'b1;
    wait_cycles(18);
    tick(0);
    check("pause_tick_inc_sec", cmd, 3'b100);
    check("pause_tick_stops", running, 0);
    PAUSE = 1'b0;
    wait_cycles(25);
    tick(0);
    check("paused_no_inc", cmd, 3'b000);
    press_pause();
    check("rerun", running, 1);

    // ADJ rising with a 1 Hz tick in RUN: no increment.
    ADJ = 1'b1;
    wait_cycles(18);
    tick(0);
    check("adj_rise_tick_no_inc", cmd, 3'b000);
    check("adj_rise_enters_adjust", running, 0);
    ADJ = 1'b0;
    wait_cycles(25);
    check("adj_rise_back_to_run", running, 1);

    // Reset in ADJUST with PAUSE held aborts the pulse and arms nothing.
    ADJ = 1'b1;
    wait_cycles(25);
    PAUSE = 1'b1;
    wait_cycles(3);
    tick(1);
    check("pre_reset_pulse", cmd, 3'b100);
    #2 RESET_N = 1'b0;
    #1 check("reset_async_clears", outs, 6'b0);
    ADJ = 1'b0;
    wait_cycles(3);
    RESET_N = 1'b1;
    wait_cycles(40);
    check("held_pause_no_event", running, 0);
    PAUSE = 1'b0;
    wait_cycles(25);
    check("release_no_event", running, 0);
    press_pause();
    check("repress_runs", running, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sw_ctrl.md
SW_CTRL -- requirements
Module: sw_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 16, consecutive stable cycles a synchronized button level needs before it is accepted.
REQ-002 Parameter: SYNC_STAGES, default 2, flip-flop depth of each input synchronizer.
REQ-003 Ports: clk  in  1  single system clock; all logic on rising edge.
REQ-004 Ports: RESET_N  in  1  asynchronous, active-low reset.
REQ-005 Ports: PAUSE  in  1  raw run/pause push-button, active-high.
REQ-006 Ports: CLR  in  1  raw clear push-button, active-high.
REQ-007 Ports: ADJ  in  1  raw adjust-mode switch, level, active-high.
REQ-008 Ports: SEL  in  1  raw field-select switch, level; 0 = minutes, 1 = seconds.
REQ-009 Ports: tick_1hz  in  1  one-cycle pulse from the clock divider, 1 Hz.
REQ-010 Ports: tick_2hz  in  1  one-cycle pulse from the clock divider, 2 Hz.
REQ-011 Ports: tick_blink  in  1  one-cycle pulse from the clock divider; toggles blink phase.
REQ-012 Ports: inc_sec  out  1  one-cycle command: advance the seconds field by one, with carry into minutes.
REQ-013 Ports: inc_min  out  1  one-cycle command: advance the minutes field only; no carry out of 59 -> 00.
REQ-014 Ports: clr  out  1  one-cycle command: clear all four digits to 00:00.
REQ-015 Ports: blank_min / blank_sec  out  1 each  blank the minutes or seconds display field.
REQ-016 Ports: running  out  1  high while the state is RUN.

Function
REQ-017 ADJ and SEL shall each be synchronized (SYNC_STAGES flops) and debounced.
REQ-018 PAUSE and CLR shall each be synchronized, debounced, and rising-edge-detected into one-cycle events pause_evt and clr_evt.
REQ-019 The FSM shall have three states: PAUSED, RUN and ADJUST; an internal flag resume_run shall record the run/pause choice.
REQ-020 PAUSED -> RUN on pause_evt; RUN -> PAUSED on pause_evt. The flag resume_run shall follow the new state.
REQ-021 Any state -> ADJUST while debounced ADJ = 1.
REQ-022 ADJUST -> RUN when ADJ falls and resume_run = 1; otherwise ADJUST -> PAUSED.
REQ-023 pause_evt shall be discarded in ADJUST.
REQ-024 All outputs shall be registered, with a latency of one cycle from the triggering tick or event.
REQ-025 In RUN, each tick_1hz shall produce exactly one inc_sec; inc_min shall be 0.
REQ-026 In ADJUST, each tick_2hz shall produce inc_min (SEL = 0) or inc_sec (SEL = 1); tick_1hz shall be ignored.
REQ-027 In PAUSED, inc_sec and inc_min shall stay 0.
REQ-028 clr_evt shall pulse clr in any state and shall not change the state.
REQ-029 If clr_evt coincides with a tick, clr shall win and the inc pulse for that tick shall be suppressed.
REQ-030 If pause_evt coincides with tick_1hz in RUN, the inc_sec for that tick shall still issue, and PAUSED shall take effect on the next cycle.
REQ-031 If ADJ rises on the same cycle as tick_1hz in RUN, no inc_sec shall be issued.
REQ-032 blink_phase shall toggle on tick_blink.
REQ-033 In ADJUST with blink_phase = 1: blank_min = ~SEL and blank_sec = SEL; otherwise both blanks = 0.
REQ-034 inc_sec, inc_min and clr shall be mutually exclusive in every cycle.

Reset
REQ-035 RESET_N low shall immediately force: state PAUSED, resume_run 0, blink_phase 0, all synchronizer and debounce registers 0, and all outputs 0.
REQ-036 Reset asserted mid-operation (including in ADJUST) shall abort any pending pulse.
REQ-037 Releasing RESET_N while a button is held shall produce no event until that button is released and pressed again.

Structure
REQ-038 Package sw_pkg shall hold the state enum (PAUSED, RUN, ADJUST) and the DEBOUNCE_CYCLES and SYNC_STAGES defaults.
REQ-039 A sub-module sw_debounce (synchronizer, stability counter, optional rise pulse) shall be instantiated once per input: PAUSE, CLR, ADJ, SEL.

Verification
REQ-040 Reset, press PAUSE 40 cycles, then 5 tick_1hz -> running = 1, 5 inc_sec pulses, each one cycle after its tick.
REQ-041 PAUSE pulse of DEBOUNCE_CYCLES-1 cycles -> no state change and no event.
REQ-042 RUN, ADJ = 1, SEL = 0, 3 tick_2hz and 2 tick_1hz -> exactly 3 inc_min, 0 inc_sec; ADJ = 0 -> returns to RUN.
REQ-043 ADJUST, SEL = 1, tick_blink pulses -> blank_sec toggles 1/0 and blank_min stays 0; a pause_evt is ignored.
REQ-044 CLR event on the same cycle as tick_1hz in RUN -> one clr pulse, no inc_sec, running stays 1.
REQ-045 RESET_N asserted in ADJUST with PAUSE held -> outputs 0 at once; after release, no pause_evt until PAUSE is re-pressed.
